// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register word indices, CTRL bit positions
// and the prescaler field range shared by the timer files.
package apb_timer_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_VALUE  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IE   = 2;

   localparam int PRESC_LSB = 8;
   localparam int PRESC_MSB = 15;

   localparam int STAT_FLAG = 0;

endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler: 8-bit divider, one tick per (presc+1)
// cycles while en=1. Ports: hclk, hresetn, en, presc, tick.
module apb_timer_prescaler (
   input  logic       hclk,
   input  logic       hresetn,
   input  logic       en,
   input  logic [7:0] presc,
   output logic       tick
);

   logic [7:0] cnt_q;

   assign tick = en & (cnt_q == presc);

   // Held at zero while stopped, so every start begins a
   // fresh prescale period.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)
         cnt_q <= '0;
      else if (!en || tick)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 8'd1;
   end

endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB down-counting timer, one-shot/periodic, level irq.
// Ports: hclk/hresetn, APB psel/penable/pwrite/paddr/pwdata/prdata, irq.
// Optional prescaler: define APB_TIMER_PRESCALE_EN.
module apb_timer
   import apb_timer_pkg::*;
#(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              irq
);

   logic             en_q, mode_q, ie_q, flag_q;
   logic             en_d, mode_d, ie_d, flag_d;
   logic [CNT_W-1:0] load_q, value_q;
   logic [CNT_W-1:0] load_d, value_d;
   logic [7:0]       presc;
   logic             tick, run_tick, expire, start;
   logic             mapped, wr;
   logic             wr_ctrl, wr_load, wr_stat;
   logic [31:0]      ctrl_rd;
   logic             unused_ok;

   assign unused_ok = ^{paddr[1:0], pwdata};

   assign mapped  = (paddr[ADDR_W-1:4] == '0);
   assign wr      = psel & penable & pwrite & mapped;
   assign wr_ctrl = wr & (paddr[3:2] == REG_CTRL);
   assign wr_load = wr & (paddr[3:2] == REG_LOAD);
   assign wr_stat = wr & (paddr[3:2] == REG_STATUS);

`ifdef APB_TIMER_PRESCALE_EN
   logic [7:0] presc_q;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)
         presc_q <= '0;
      else if (wr_ctrl)
         presc_q <= pwdata[PRESC_MSB:PRESC_LSB];
   end

   assign presc = presc_q;
`else
   // A zero divisor makes the prescaler pass en straight through.
   assign presc = 8'h00;
`endif

   apb_timer_prescaler u_presc (
      .hclk    (hclk),
      .hresetn (hresetn),
      .en      (en_q),
      .presc   (presc),
      .tick    (tick)
   );

   // A stopping CTRL write freezes VALUE on its own edge.
   assign run_tick = tick & ~(wr_ctrl & ~pwdata[CTRL_EN]);
   assign expire   = run_tick & (value_q == '0);
   assign start    = wr_ctrl & pwdata[CTRL_EN] & ~en_q;

   always_comb begin
      en_d    = en_q;
      mode_d  = mode_q;
      ie_d    = ie_q;
      flag_d  = flag_q;
      load_d  = load_q;
      value_d = value_q;
      if (run_tick) begin
         if (value_q != '0)
            value_d = value_q - CNT_W'(1);
         else if (mode_q)
            value_d = load_q;
         else
            en_d = 1'b0;
      end
      if (wr_ctrl) begin
         en_d   = pwdata[CTRL_EN];
         mode_d = pwdata[CTRL_MODE];
         ie_d   = pwdata[CTRL_IE];
      end
      if (start)
         value_d = load_q;
      if (wr_load)
         load_d = pwdata[CNT_W-1:0];
      if (wr_stat && pwdata[STAT_FLAG])
         flag_d = 1'b0;
      if (expire)
         flag_d = 1'b1;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         en_q    <= 1'b0;
         mode_q  <= 1'b0;
         ie_q    <= 1'b0;
         flag_q  <= 1'b0;
         load_q  <= '0;
         value_q <= '0;
      end else begin
         en_q    <= en_d;
         mode_q  <= mode_d;
         ie_q    <= ie_d;
         flag_q  <= flag_d;
         load_q  <= load_d;
         value_q <= value_d;
      end
   end

   always_comb begin
      ctrl_rd            = '0;
      ctrl_rd[CTRL_EN]   = en_q;
      ctrl_rd[CTRL_MODE] = mode_q;
      ctrl_rd[CTRL_IE]   = ie_q;
`ifdef APB_TIMER_PRESCALE_EN
      ctrl_rd[PRESC_MSB:PRESC_LSB] = presc_q;
`endif
   end

   always_comb begin
      prdata = '0;
      if (psel && !pwrite && mapped) begin
         unique case (paddr[3:2])
            REG_CTRL:   prdata = ctrl_rd;
            REG_LOAD:   prdata = 32'(load_q);
            REG_VALUE:  prdata = 32'(value_q);
            REG_STATUS: prdata = {31'b0, flag_q};
         endcase
      end
   end

   assign irq = flag_q & ie_q;

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed bench for apb_timer with
// hand-computed expected register and irq values.
module tb_apb_timer;

   logic        hclk;
   logic        hresetn;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        irq;

   int errs   = 0;
   int checks = 0;

   localparam logic [11:0] A_CTRL  = 12'h000;
   localparam logic [11:0] A_LOAD  = 12'h004;
   localparam logic [11:0] A_VALUE = 12'h008;
   localparam logic [11:0] A_STAT  = 12'h00C;
   localparam logic [11:0] A_BAD   = 12'h010;

   apb_timer #(
      .ADDR_W (12),
      .CNT_W  (32)
   ) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .irq     (irq)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; commits on the second posedge,
   // returns at the negedge right after the commit.
   task automatic wr(input logic [11:0] a,
                     input logic [31:0] d);
      psel    = 1'b1;
      pwrite  = 1'b1;
      penable = 1'b0;
      paddr   = a;
      pwdata  = d;
      @(negedge hclk);
      penable = 1'b1;
      @(negedge hclk);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic pchk(input string tag,
                       input logic [11:0] a,
                       input logic [31:0] exp);
      psel    = 1'b1;
      pwrite  = 1'b0;
      penable = 1'b0;
      paddr   = a;
      #1;
      chk(tag, prdata, exp);
   endtask

   initial begin
      hresetn = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;
      @(negedge hclk);

      pchk("rst_ctrl", A_CTRL, 32'h0);
      pchk("rst_load", A_LOAD, 32'h0);
      pchk("rst_value", A_VALUE, 32'h0);
      pchk("rst_stat", A_STAT, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);

      wr(A_LOAD, 32'd3);
      pchk("load_rb", A_LOAD, 32'd3);
      pwrite = 1'b1;
      #1;
      chk("rd_gate_pwrite", prdata, 32'h0);
      pwrite = 1'b0;

      wr(A_CTRL, 32'h3);
      for (int k = 0; k < 10; k++) begin
         pchk($sformatf("per_val%0d", k), A_VALUE,
              32'(3 - (k % 4)));
         pchk($sformatf("per_flag%0d", k), A_STAT,
              (k >= 4) ? 32'h1 : 32'h0);
         @(negedge hclk);
      end
      wr(A_CTRL, 32'h0);
      pchk("stop_ctrl", A_CTRL, 32'h0);
      wr(A_STAT, 32'h1);
      pchk("w1c_clear", A_STAT, 32'h0);

      wr(A_LOAD, 32'd0);
      wr(A_CTRL, 32'h7);
      pchk("start_no_tick", A_STAT, 32'h0);
      wr(A_STAT, 32'h1);
      pchk("set_beats_w1c", A_STAT, 32'h1);
      chk("set_irq", {31'b0, irq}, 32'h1);
      wr(A_CTRL, 32'h0);
      chk("ie_off_irq", {31'b0, irq}, 32'h0);
      wr(A_STAT, 32'h1);
      pchk("w1c_clear2", A_STAT, 32'h0);

      wr(A_LOAD, 32'd2);
      wr(A_CTRL, 32'h5);
      for (int k = 0; k < 6; k++) begin
         pchk($sformatf("os_val%0d", k), A_VALUE,
              (k < 2) ? 32'(2 - k) : 32'h0);
         chk($sformatf("os_irq%0d", k), {31'b0, irq},
             (k >= 3) ? 32'h1 : 32'h0);
         @(negedge hclk);
      end
      pchk("os_en_clr", A_CTRL, 32'h4);
      wr(A_STAT, 32'h1);
      chk("os_irq_clr", {31'b0, irq}, 32'h0);

      pchk("unmap_rd", A_BAD, 32'h0);
      wr(A_BAD, 32'hFFFF_FFFF);
      pchk("unmap_ctrl", A_CTRL, 32'h4);
      pchk("unmap_load", A_LOAD, 32'd2);
      pchk("unmap_stat", A_STAT, 32'h0);
      wr(A_VALUE, 32'd5);
      pchk("value_ro", A_VALUE, 32'h0);

`ifdef APB_TIMER_PRESCALE_EN
      wr(A_LOAD, 32'd1);
      wr(A_CTRL, 32'h0303);
      pchk("presc_ctrl", A_CTRL, 32'h0303);
      for (int k = 0; k < 12; k++) begin
         pchk($sformatf("ps_val%0d", k), A_VALUE,
              (((k / 4) % 2) == 0) ? 32'h1 : 32'h0);
         pchk($sformatf("ps_flag%0d", k), A_STAT,
              (k >= 8) ? 32'h1 : 32'h0);
         @(negedge hclk);
      end
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h1);
`else
      wr(A_CTRL, 32'h0000_FF00);
      pchk("presc_absent", A_CTRL, 32'h0);
`endif

      wr(A_LOAD, 32'd3);
      wr(A_CTRL, 32'h7);
      repeat (6) @(negedge hclk);
      chk("pre_rst_irq", {31'b0, irq}, 32'h1);
      hresetn = 1'b0;
      pchk("rst_mid_val", A_VALUE, 32'h0);
      chk("rst_mid_irq", {31'b0, irq}, 32'h0);
      @(negedge hclk);
      hresetn = 1'b1;
      pchk("rst_post_val", A_VALUE, 32'h0);
      pchk("rst_post_ctrl", A_CTRL, 32'h0);
      pchk("rst_post_load", A_LOAD, 32'h0);
      psel = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
